// File: rtl/cart_mem_sequencer.sv
// cart_mem_sequencer
//
// Serialises the mapped PRG (CPU) and CHR (PPU) accesses from a mapper onto a
// single cartridge memory port with a req/ack handshake. Each side owns one
// pending slot. An access granted with allow=0 completes without a memory
// cycle. An access whose ack never arrives is aborted after TIMEOUT cycles.
//
// Ports
//   clk, reset               system clock, synchronous active-high reset
//   prg_req/aout/write/din/allow   CPU strobe and its qualifiers (sampled on strobe)
//   prg_dout, prg_done       CPU read data (held) and one-cycle completion pulse
//   chr_*                    same set for the PPU side
//   mem_req/we/addr/wdata    memory request, held until ack or timeout
//   mem_ack, mem_rdata       one-cycle ack with same-cycle read data
//   err_timeout, err_overrun sticky error flags
module cart_mem_sequencer #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  // CPU side
  input  logic        prg_req,
  input  logic [21:0] prg_aout,
  input  logic        prg_write,
  input  logic [7:0]  prg_din,
  input  logic        prg_allow,
  output logic [7:0]  prg_dout,
  output logic        prg_done,
  // PPU side
  input  logic        chr_req,
  input  logic [21:0] chr_aout,
  input  logic        chr_write,
  input  logic [7:0]  chr_din,
  input  logic        chr_allow,
  output logic [7:0]  chr_dout,
  output logic        chr_done,
  // Memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  // Status
  output logic        err_timeout,
  output logic        err_overrun
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // Abort on the edge that would take the count to TIMEOUT, so mem_req is
  // high for exactly TIMEOUT cycles.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StFinish
  } state_e;

  state_e state_q, state_d;

  // Pending slots
  logic        pend_p, pend_c;
  logic [21:0] slot_p_addr, slot_c_addr;
  logic        slot_p_we, slot_c_we;
  logic [7:0]  slot_p_wdata, slot_c_wdata;
  logic        slot_p_allow, slot_c_allow;

  // Service bookkeeping
  logic            sel_chr_q;   // side currently granted (1 = CHR)
  logic            last_chr_q;  // side that completed last (1 = CHR)
  logic [CntW-1:0] cnt_q;

  // Grant view of the slots
  logic        grant_any, grant_chr;
  logic [21:0] g_addr;
  logic        g_we;
  logic [7:0]  g_wdata;
  logic        g_allow;

  // FSM control
  logic       start_mem;
  logic       load_dout;
  logic       load_chr;
  logic [7:0] load_val;
  logic       set_tmo;

  // CHR has default priority; PRG wins a tie only right after a CHR access.
  assign grant_any = pend_p | pend_c;
  assign grant_chr = pend_c & (~pend_p | ~last_chr_q);

  assign g_addr  = grant_chr ? slot_c_addr  : slot_p_addr;
  assign g_we    = grant_chr ? slot_c_we    : slot_p_we;
  assign g_wdata = grant_chr ? slot_c_wdata : slot_p_wdata;
  assign g_allow = grant_chr ? slot_c_allow : slot_p_allow;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    start_mem = 1'b0;
    load_dout = 1'b0;
    load_chr  = sel_chr_q;
    load_val  = OPEN_BUS;
    set_tmo   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          load_chr = grant_chr;
          if (g_allow) begin
            start_mem = 1'b1;
            state_d   = StIssue;
          end else begin
            // Disallowed: reads see open bus, writes vanish.
            load_dout = ~g_we;
            state_d   = StFinish;
          end
        end
      end

      StIssue: begin
        // Ack takes precedence over a timeout firing in the same cycle.
        if (mem_ack) begin
          load_dout = ~mem_we;
          load_val  = mem_rdata;
          state_d   = StFinish;
        end else if (cnt_q == CntLast) begin
          load_dout = ~mem_we;
          set_tmo   = 1'b1;
          state_d   = StFinish;
        end
      end

      StFinish: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Done pulses are decoded from the FINISH state; dout is loaded on the edge
  // into FINISH so that it is already valid while done is high.
  assign prg_done = (state_q == StFinish) & ~sel_chr_q;
  assign chr_done = (state_q == StFinish) &  sel_chr_q;

  // ---------------------------------------------------------------------------
  // Pending slots and overrun detection
  // ---------------------------------------------------------------------------
  // A slot stays pending through its whole service, including FINISH, so any
  // strobe for that side in that window is an overrun and leaves it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_p       <= 1'b0;
      slot_p_addr  <= '0;
      slot_p_we    <= 1'b0;
      slot_p_wdata <= '0;
      slot_p_allow <= 1'b0;
      pend_c       <= 1'b0;
      slot_c_addr  <= '0;
      slot_c_we    <= 1'b0;
      slot_c_wdata <= '0;
      slot_c_allow <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      if ((state_q == StFinish) && !sel_chr_q) begin
        pend_p <= 1'b0;
      end else if (prg_req && !pend_p) begin
        pend_p       <= 1'b1;
        slot_p_addr  <= prg_aout;
        slot_p_we    <= prg_write;
        slot_p_wdata <= prg_din;
        slot_p_allow <= prg_allow;
      end

      if ((state_q == StFinish) && sel_chr_q) begin
        pend_c <= 1'b0;
      end else if (chr_req && !pend_c) begin
        pend_c       <= 1'b1;
        slot_c_addr  <= chr_aout;
        slot_c_we    <= chr_write;
        slot_c_wdata <= chr_din;
        slot_c_allow <= chr_allow;
      end

      if ((prg_req && pend_p) || (chr_req && pend_c)) begin
        err_overrun <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Grant tracking, memory port, timeout counter, read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_chr_q   <= 1'b0;
      last_chr_q  <= 1'b0;
      cnt_q       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      err_timeout <= 1'b0;
      prg_dout    <= OPEN_BUS;
      chr_dout    <= OPEN_BUS;
    end else begin
      if ((state_q == StIdle) && grant_any) begin
        sel_chr_q <= grant_chr;
      end
      if (state_q == StFinish) begin
        last_chr_q <= sel_chr_q;
      end

      // Address/data are only loaded at grant, so they stay stable during req.
      if (start_mem) begin
        mem_addr  <= g_addr;
        mem_we    <= g_we;
        mem_wdata <= g_wdata;
        cnt_q     <= '0;
      end else if (state_q == StIssue) begin
        cnt_q <= cnt_q + CntW'(1);
      end

      mem_req <= (state_d == StIssue);

      if (set_tmo) begin
        err_timeout <= 1'b1;
      end

      if (load_dout) begin
        if (load_chr) begin
          chr_dout <= load_val;
        end else begin
          prg_dout <= load_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_cart_mem_sequencer.sv
module tb_cart_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        prg_req, prg_write, prg_allow;
  logic [21:0] prg_aout;
  logic [7:0]  prg_din, prg_dout;
  logic        prg_done;
  logic        chr_req, chr_write, chr_allow;
  logic [21:0] chr_aout;
  logic [7:0]  chr_din, chr_dout;
  logic        chr_done;
  logic        mem_req, mem_we, mem_ack;
  logic [21:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        err_timeout, err_overrun;

  cart_mem_sequencer #(
    .TIMEOUT (15),
    .OPEN_BUS(8'hFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .prg_req    (prg_req),
    .prg_aout   (prg_aout),
    .prg_write  (prg_write),
    .prg_din    (prg_din),
    .prg_allow  (prg_allow),
    .prg_dout   (prg_dout),
    .prg_done   (prg_done),
    .chr_req    (chr_req),
    .chr_aout   (chr_aout),
    .chr_write  (chr_write),
    .chr_din    (chr_din),
    .chr_allow  (chr_allow),
    .chr_dout   (chr_dout),
    .chr_done   (chr_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        chr;
    logic        wr;
    logic [21:0] addr;
    logic [7:0]  wdata;
    logic        allow;
    int          ack_delay;  // mem_req cycles before ack; -1 = never
    logic [7:0]  rdata;
    int          exp_req;    // cycles mem_req is high
    int          exp_done;   // done cycle, strobe = cycle 0
    logic [7:0]  exp_dout;
    logic        exp_tmo;
  } vec_t;

  vec_t vecs[7];

  // Monitor results
  int          n_mc, req_cycles, unstable;
  logic [21:0] mc_addr[8];
  logic        mc_we[8];
  logic [7:0]  mc_wdata[8];
  int          prg_done_cyc, chr_done_cyc, prg_done_n, chr_done_n;
  logic [7:0]  prg_dout_at_done, chr_dout_at_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic chr, input logic wr, input logic [21:0] addr,
                        input logic [7:0] wdata, input logic allow);
    if (chr) begin
      chr_aout = addr; chr_write = wr; chr_din = wdata; chr_allow = allow; chr_req = 1'b1;
    end else begin
      prg_aout = addr; prg_write = wr; prg_din = wdata; prg_allow = allow; prg_req = 1'b1;
    end
    tick;
    prg_req = 1'b0;
    chr_req = 1'b0;
  endtask

  // Runs ncyc cycles acting as the memory and recording what the DUT does.
  task automatic monitor(input int start_cyc, input int ncyc, input int ack_delay,
                         input logic [7:0] rdata);
    int          run;
    logic        prev;
    logic [30:0] last_bus;
    run = 0; prev = 1'b0; last_bus = '0;
    n_mc = 0; req_cycles = 0; unstable = 0;
    prg_done_cyc = -1; chr_done_cyc = -1; prg_done_n = 0; chr_done_n = 0;
    prg_dout_at_done = 8'h00; chr_dout_at_done = 8'h00;
    for (int c = start_cyc; c < start_cyc + ncyc; c++) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        req_cycles++;
        run++;
        if (!prev) begin
          if (n_mc < 8) begin
            mc_addr[n_mc] = mem_addr; mc_we[n_mc] = mem_we; mc_wdata[n_mc] = mem_wdata;
          end
          n_mc++;
        end else if ({mem_we, mem_wdata, mem_addr} !== last_bus) begin
          unstable++;
        end
        last_bus = {mem_we, mem_wdata, mem_addr};
        if (ack_delay >= 0 && run == ack_delay + 1) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
      end else begin
        run = 0;
      end
      prev = mem_req;
      if (prg_done) begin
        prg_done_n++;
        if (prg_done_cyc < 0) begin prg_done_cyc = c; prg_dout_at_done = prg_dout; end
      end
      if (chr_done) begin
        chr_done_n++;
        if (chr_done_cyc < 0) begin chr_done_cyc = c; chr_dout_at_done = chr_dout; end
      end
      tick;
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int spur;
    vecs[0] = '{1'b0, 1'b0, 22'h004123, 8'h00, 1'b1,  3, 8'hA5,  4,  6, 8'hA5, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 22'h000010, 8'h3C, 1'b1,  1, 8'h00,  2,  4, 8'hA5, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 22'h200005, 8'h00, 1'b1,  0, 8'h5A,  1,  3, 8'h5A, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 22'h000020, 8'h00, 1'b0,  0, 8'h00,  0,  2, 8'hFF, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 22'h200007, 8'h77, 1'b0,  0, 8'h00,  0,  2, 8'h5A, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 22'h000030, 8'h00, 1'b1, -1, 8'h00, 15, 17, 8'hFF, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 22'h200008, 8'h00, 1'b1,  2, 8'hC3,  3,  5, 8'hC3, 1'b1};

    reset = 1'b1;
    prg_req = 0; prg_write = 0; prg_allow = 0; prg_aout = '0; prg_din = '0;
    chr_req = 0; chr_write = 0; chr_allow = 0; chr_aout = '0; chr_din = '0;
    mem_ack = 0; mem_rdata = '0;
    tick; tick;
    reset = 1'b0;

    // Reset state
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_done", 32'({prg_done, chr_done}), 32'd0);
    check("rst_errs", 32'({err_timeout, err_overrun}), 32'd0);
    check("rst_prg_dout", 32'(prg_dout), 32'hFF);
    check("rst_chr_dout", 32'(chr_dout), 32'hFF);

    // Single-side transactions
    for (int i = 0; i < 7; i++) begin
      strobe(vecs[i].chr, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].allow);
      monitor(1, 22, vecs[i].ack_delay, vecs[i].rdata);
      check($sformatf("v%0d_req_cycles", i), 32'(req_cycles), 32'(vecs[i].exp_req));
      check($sformatf("v%0d_stable", i), 32'(unstable), 32'd0);
      if (vecs[i].exp_req > 0) begin
        check($sformatf("v%0d_addr", i), 32'(mc_addr[0]), 32'(vecs[i].addr));
        check($sformatf("v%0d_we", i), 32'(mc_we[0]), 32'(vecs[i].wr));
        check($sformatf("v%0d_wdata", i), 32'(mc_wdata[0]), 32'(vecs[i].wdata));
      end
      if (vecs[i].chr) begin
        check($sformatf("v%0d_done_cyc", i), 32'(chr_done_cyc), 32'(vecs[i].exp_done));
        check($sformatf("v%0d_done_n", i), 32'(chr_done_n), 32'd1);
        check($sformatf("v%0d_other_done", i), 32'(prg_done_n), 32'd0);
        check($sformatf("v%0d_dout", i), 32'(chr_dout_at_done), 32'(vecs[i].exp_dout));
      end else begin
        check($sformatf("v%0d_done_cyc", i), 32'(prg_done_cyc), 32'(vecs[i].exp_done));
        check($sformatf("v%0d_done_n", i), 32'(prg_done_n), 32'd1);
        check($sformatf("v%0d_other_done", i), 32'(chr_done_n), 32'd0);
        check($sformatf("v%0d_dout", i), 32'(prg_dout_at_done), 32'(vecs[i].exp_dout));
      end
      check($sformatf("v%0d_err_timeout", i), 32'(err_timeout), 32'(vecs[i].exp_tmo));
    end
    check("tbl_no_overrun", 32'(err_overrun), 32'd0);
    check("tbl_prg_dout_hold", 32'(prg_dout), 32'hFF);

    // Overrun: second CHR strobe while the first is in ISSUE
    chr_aout = 22'h200040; chr_write = 0; chr_allow = 1; chr_req = 1;
    tick;
    chr_req = 0;
    tick;
    check("ovr_req_up", 32'(mem_req), 32'd1);
    chr_aout = 22'h3FFFFF; chr_req = 1;
    tick;
    chr_req = 0; chr_aout = '0;
    monitor(3, 15, 2, 8'h9E);
    check("ovr_flag", 32'(err_overrun), 32'd1);
    check("ovr_done_n", 32'(chr_done_n), 32'd1);
    check("ovr_mem_cycles", 32'(n_mc), 32'd1);
    check("ovr_addr", 32'(mc_addr[0]), 32'h200040);
    check("ovr_stable", 32'(unstable), 32'd0);
    check("ovr_dout", 32'(chr_dout), 32'h9E);

    // Spurious acks while idle
    spur = 0;
    mem_rdata = 8'hE1;
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1;
      tick;
      if (mem_req || prg_done || chr_done) spur++;
    end
    mem_ack = 0;
    tick;
    if (mem_req || prg_done || chr_done) spur++;
    check("spur_activity", 32'(spur), 32'd0);
    check("spur_chr_dout", 32'(chr_dout), 32'h9E);
    check("spur_prg_dout", 32'(prg_dout), 32'hFF);

    // Reset during ISSUE
    strobe(1'b0, 1'b0, 22'h000040, 8'h00, 1'b1);
    tick; tick;
    check("rmid_req_up", 32'(mem_req), 32'd1);
    check("rmid_errs_before", 32'({err_timeout, err_overrun}), 32'h3);
    reset = 1;
    tick;
    reset = 0;
    check("rmid_req_down", 32'(mem_req), 32'd0);
    check("rmid_errs", 32'({err_timeout, err_overrun}), 32'd0);
    check("rmid_prg_dout", 32'(prg_dout), 32'hFF);
    check("rmid_chr_dout", 32'(chr_dout), 32'hFF);
    monitor(0, 6, -1, 8'h00);
    check("rmid_no_done", 32'(prg_done_n + chr_done_n), 32'd0);
    check("rmid_no_req", 32'(req_cycles), 32'd0);
    strobe(1'b0, 1'b0, 22'h000200, 8'h00, 1'b1);
    monitor(1, 8, 0, 8'h11);
    check("rpost_done_cyc", 32'(prg_done_cyc), 32'd3);
    check("rpost_dout", 32'(prg_dout_at_done), 32'h11);
    check("rpost_addr", 32'(mc_addr[0]), 32'h000200);

    // Simultaneous pair, last grant PRG: CHR served first
    prg_aout = 22'h000010; prg_write = 1; prg_din = 8'h3C; prg_allow = 1; prg_req = 1;
    chr_aout = 22'h200005; chr_write = 0; chr_din = 8'h00; chr_allow = 1; chr_req = 1;
    tick;
    prg_req = 0; chr_req = 0;
    monitor(1, 12, 0, 8'h66);
    check("pair1_mem_cycles", 32'(n_mc), 32'd2);
    check("pair1_first_addr", 32'(mc_addr[0]), 32'h200005);
    check("pair1_first_we", 32'(mc_we[0]), 32'd0);
    check("pair1_second_addr", 32'(mc_addr[1]), 32'h000010);
    check("pair1_second_we", 32'(mc_we[1]), 32'd1);
    check("pair1_second_wdata", 32'(mc_wdata[1]), 32'h3C);
    check("pair1_chr_done_cyc", 32'(chr_done_cyc), 32'd3);
    check("pair1_prg_done_cyc", 32'(prg_done_cyc), 32'd6);
    check("pair1_chr_dout", 32'(chr_dout_at_done), 32'h66);
    check("pair1_prg_dout_hold", 32'(prg_dout_at_done), 32'h11);

    // A CHR access makes CHR the last grant, so the next pair goes PRG first
    strobe(1'b1, 1'b0, 22'h200100, 8'h00, 1'b1);
    monitor(1, 6, 0, 8'h44);
    check("mid_chr_dout", 32'(chr_dout_at_done), 32'h44);
    prg_aout = 22'h000300; prg_write = 0; prg_allow = 1; prg_req = 1;
    chr_aout = 22'h200300; chr_write = 0; chr_allow = 1; chr_req = 1;
    tick;
    prg_req = 0; chr_req = 0;
    monitor(1, 12, 0, 8'h77);
    check("pair2_first_addr", 32'(mc_addr[0]), 32'h000300);
    check("pair2_second_addr", 32'(mc_addr[1]), 32'h200300);
    check("pair2_prg_done_cyc", 32'(prg_done_cyc), 32'd3);
    check("pair2_chr_done_cyc", 32'(chr_done_cyc), 32'd6);
    check("pair2_prg_dout", 32'(prg_dout_at_done), 32'h77);
    check("pair2_chr_dout", 32'(chr_dout_at_done), 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cart_mem_sequencer.md
Name: cart_mem_sequencer

Overview:
- Consumer side of the mapper interface. Takes the mapped PRG and CHR addresses and allow qualifiers that a mapper produces.
- Serialises them onto the single cartridge memory port (SDRAM/BRAM controller) using a req/ack handshake.
- Returns read data to the CPU and PPU sides with done pulses.
- Sits between the mapper instance and the memory controller in the cartridge top level.

Parameters:
- TIMEOUT, 15: max cycles mem_req stays high without mem_ack before the access is aborted.
- OPEN_BUS, 8'hFF: data returned for disallowed or aborted reads.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- prg_req  in  1  one-cycle strobe: CPU access to cartridge space
- prg_aout  in  22  mapped PRG address from mapper
- prg_write  in  1  1=write, 0=read (sampled with prg_req)
- prg_din  in  8  CPU write data
- prg_allow  in  1  mapper permits memory access (sampled with prg_req)
- prg_dout  out  8  PRG read data, valid when prg_done
- prg_done  out  1  one-cycle completion pulse
- chr_req, chr_aout[21:0], chr_write, chr_din[7:0], chr_allow  in  same meaning as the PRG ports, PPU side
- chr_dout  out  8, chr_done  out  1  same meaning as the PRG ports, PPU side
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  write enable, stable while mem_req
- mem_addr  out  22  memory address, stable while mem_req
- mem_wdata  out  8  write data, stable while mem_req
- mem_ack  in  1  one-cycle acknowledge; read data valid same cycle
- mem_rdata  in  8  read data
- err_timeout  out  1  sticky: an access was aborted
- err_overrun  out  1  sticky: a request was dropped

Behaviour:
- Reset values: all outputs 0, except prg_dout and chr_dout, which reset to OPEN_BUS. Pending latches clear. FSM goes to IDLE.
- On prg_req (chr_req), capture the address, write flag, data and allow into that side's pending slot; set pend_p (pend_c).
- If a req arrives while the same side is pending or in service, drop it (slot unchanged) and set err_overrun.
- FSM has three states: IDLE, ISSUE, FINISH.
- IDLE:
  - If neither side is pending, stay in IDLE.
  - Grant choice: CHR wins if both pending, unless last_grant==CHR, in which case PRG wins (alternating priority).
  - Granted side with allow=0: no memory cycle. Go to FINISH with data=OPEN_BUS for a read; a write is discarded.
  - Granted side with allow=1: drive mem_addr/mem_we/mem_wdata from the slot, assert mem_req next cycle, clear the timeout counter, go to ISSUE.
  - A req strobe and a grant for an already-pending slot in the same cycle: the strobe counts as overrun.
  - A req strobe on a non-pending side in the same cycle as IDLE grant evaluation: it is latched but not considered until the next IDLE cycle.
- ISSUE:
  - mem_req stays high. The counter increments every cycle without ack.
  - On mem_ack: capture mem_rdata (reads only), drop mem_req in the same clock edge, go to FINISH.
  - When the counter reaches TIMEOUT with no ack: drop mem_req, set err_timeout, data=OPEN_BUS, go to FINISH.
  - An ack arriving on the cycle the timeout fires counts as an ack (ack wins).
- FINISH:
  - Pulse the granted side's done for exactly one cycle.
  - Update that side's dout for reads; a write leaves dout unchanged.
  - Clear the side's pending flag, record last_grant, return to IDLE.
- Latency, allowed access, idle sequencer, ack on the first mem_req cycle: strobe at cycle 0, pending at 1, mem_req at 2, ack at 2, done at 3.
- Back-to-back: IDLE can grant the other side on the cycle after FINISH. There is a minimum of 1 IDLE cycle between memory cycles.
- Spurious mem_ack outside ISSUE is ignored.
- Reset mid-operation: mem_req falls on the next edge. Pending flags clear, no done pulse, sticky errors clear.
- dout values hold between accesses. Counter width is clog2(TIMEOUT+1).

Test Plan:
- Single PRG read at 22'h00_4123, allow=1; memory acks after 3 cycles with 8'hA5 -> mem_addr=22'h004123, mem_we=0 during req, prg_done one pulse, prg_dout=8'hA5, chr_done never pulses.
- Simultaneous prg_req (write 8'h3C to 22'h000010) and chr_req (read 22'h200005), last_grant=PRG -> CHR memory cycle first, then PRG write with mem_we=1 and mem_wdata=8'h3C. A second simultaneous pair is then served in PRG-first order.
- prg_req with prg_allow=0, read -> no mem_req ever asserted; prg_done 2 cycles after strobe; prg_dout=8'hFF.
- mem_ack withheld, TIMEOUT=15 -> mem_req high exactly 15 cycles then low; err_timeout=1 stays set; prg_dout=8'hFF. A later normal access still completes.
- Second chr_req while the first CHR access is in ISSUE -> err_overrun=1; only one chr_done; mem_addr unchanged from the first request.
- reset asserted during ISSUE -> mem_req=0 next cycle, no done pulse, err flags=0, prg_dout=chr_dout=8'hFF. A request after reset deasserts completes normally.
